// File: rtl/canny_window_sequencer_if.sv
// Control, pixel, core and edge-result signals for canny_window_sequencer.
// With CANNY_SEQ_EDGE_COUNT_EN defined, an edge_count output is also carried.
interface canny_window_sequencer_if #(
  parameter int DIM_W = 12
);
  logic [DIM_W-1:0]   cfg_width;
  logic [DIM_W-1:0]   cfg_height;
  logic               go;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic               pix_valid;
  logic               pix_ready;
  logic [15:0]        pix_data;
  logic               win_start;
  logic [143:0]       win_bus;
  logic               core_valid;
  logic [15:0]        core_dxy;
  logic               edge_valid;
  logic               edge_ready;
  logic [7:0]         edge_data;
  logic               edge_last;
`ifdef CANNY_SEQ_EDGE_COUNT_EN
  logic [2*DIM_W-1:0] edge_count;
`endif

  // The sequencer takes the master side; source, core and sink share the slave side.
  modport master (
    input  cfg_width, cfg_height, go, pix_valid, pix_data, core_valid, core_dxy, edge_ready,
    output busy, done, cfg_err, pix_ready, win_start, win_bus, edge_valid, edge_data, edge_last
`ifdef CANNY_SEQ_EDGE_COUNT_EN
    , output edge_count
`endif
  );

  modport slave (
    output cfg_width, cfg_height, go, pix_valid, pix_data, core_valid, core_dxy, edge_ready,
    input  busy, done, cfg_err, pix_ready, win_start, win_bus, edge_valid, edge_data, edge_last
`ifdef CANNY_SEQ_EDGE_COUNT_EN
    , input edge_count
`endif
  );
endinterface

// File: rtl/canny_window_sequencer.sv
// Builds 3x3 windows from a raster stream, hands them one at a time to the canny core
// and streams the thresholded results out. Optional macro: CANNY_SEQ_EDGE_COUNT_EN.
module canny_window_sequencer #(
  parameter int MAX_WIDTH = 640,
  parameter int DIM_W     = 12
) (
  input logic                     clk,
  input logic                     reset,
  canny_window_sequencer_if.master bus
);
  localparam int AW = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, ACCEPT, ISSUE, WAIT, OUT, DONE} state_t;

  state_t           state;
  logic [DIM_W-1:0] width;
  logic [DIM_W-1:0] height;
  logic [DIM_W-1:0] row;
  logic [DIM_W-1:0] col;
  logic             last_win;
  logic [15:0]      lb0 [MAX_WIDTH];
  logic [15:0]      lb1 [MAX_WIDTH];
  logic [AW-1:0]    col_idx;
  logic [15:0]      lb_top;
  logic [15:0]      lb_mid;
  logic [143:0]     win_next;
  logic             pix_fire;
  logic             cfg_ok;

  assign col_idx       = AW'(col);
  assign lb_top        = lb1[col_idx];
  assign lb_mid        = lb0[col_idx];
  assign pix_fire      = (state == ACCEPT) && bus.pix_valid;
  assign bus.pix_ready = (state == ACCEPT);
  assign cfg_ok        = (bus.cfg_width >= DIM_W'(3)) &&
                         (bus.cfg_width <= DIM_W'(MAX_WIDTH)) &&
                         (bus.cfg_height >= DIM_W'(3));

  // Each row of the window slides one column left; the new right column is
  // two rows back, one row back and the incoming pixel.
  always_comb begin
    win_next = bus.win_bus;
    for (int i = 0; i < 3; i++) begin
      win_next[i*48 +: 32] = bus.win_bus[i*48+16 +: 32];
    end
    win_next[32  +: 16] = lb_top;
    win_next[80  +: 16] = lb_mid;
    win_next[128 +: 16] = bus.pix_data;
  end

  // Line buffers are plain storage; stale contents are never issued in a window.
  always_ff @(posedge clk) begin
    if (pix_fire) begin
      lb1[col_idx] <= lb_mid;
      lb0[col_idx] <= bus.pix_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      width          <= '0;
      height         <= '0;
      row            <= '0;
      col            <= '0;
      last_win       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.cfg_err    <= 1'b0;
      bus.win_start  <= 1'b0;
      bus.win_bus    <= '0;
      bus.edge_valid <= 1'b0;
      bus.edge_data  <= '0;
      bus.edge_last  <= 1'b0;
`ifdef CANNY_SEQ_EDGE_COUNT_EN
      bus.edge_count <= '0;
`endif
    end else begin
      bus.done      <= 1'b0;
      bus.cfg_err   <= 1'b0;
      bus.win_start <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.go) begin
            if (cfg_ok) begin
              width    <= bus.cfg_width;
              height   <= bus.cfg_height;
              row      <= '0;
              col      <= '0;
              bus.busy <= 1'b1;
              state    <= ACCEPT;
`ifdef CANNY_SEQ_EDGE_COUNT_EN
              bus.edge_count <= '0;
`endif
            end else begin
              bus.cfg_err <= 1'b1;
            end
          end
        end
        ACCEPT: begin
          if (bus.pix_valid) begin
            bus.win_bus <= win_next;
            last_win    <= (row == height - DIM_W'(1)) && (col == width - DIM_W'(1));
            if (col == width - DIM_W'(1)) begin
              col <= '0;
              row <= row + DIM_W'(1);
            end else begin
              col <= col + DIM_W'(1);
            end
            if ((row >= DIM_W'(2)) && (col >= DIM_W'(2))) begin
              bus.win_start <= 1'b1;
              state         <= ISSUE;
            end
          end
        end
        ISSUE: begin
          state <= WAIT;
        end
        WAIT: begin
          if (bus.core_valid) begin
            bus.edge_data  <= 8'(bus.core_dxy);
            bus.edge_last  <= last_win;
            bus.edge_valid <= 1'b1;
            state          <= OUT;
          end
        end
        OUT: begin
          if (bus.edge_ready) begin
            bus.edge_valid <= 1'b0;
            bus.edge_last  <= 1'b0;
`ifdef CANNY_SEQ_EDGE_COUNT_EN
            if (bus.edge_data == 8'hFF) begin
              bus.edge_count <= bus.edge_count + (2*DIM_W)'(1);
            end
`endif
            if (bus.edge_last) begin
              bus.done <= 1'b1;
              state    <= DONE;
            end else begin
              state <= ACCEPT;
            end
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_canny_window_sequencer.sv
// Directed bench for canny_window_sequencer: acts as pixel source, canny core and edge sink,
// scoring windows and edge results against a model of the frame image.
module tb_canny_window_sequencer;
  localparam int DIM_W     = 12;
  localparam int MAX_WIDTH = 640;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  canny_window_sequencer_if #(.DIM_W(DIM_W)) bus ();

  canny_window_sequencer #(.MAX_WIDTH(MAX_WIDTH), .DIM_W(DIM_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [15:0]  img [64];
  int           fw;
  int           fh;
  int           win_q[$];
  logic [8:0]   edge_q[$];
  logic [7:0]   result_log[$];
  logic [143:0] first_win_obs;

  task automatic checkOutput(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // kind 0: all zero, 1: step at column 2 (0,0,100,...), 2: random 0..255
  task automatic fill_image(input int w, input int h, input int kind);
    fw = w;
    fh = h;
    for (int i = 0; i < w*h; i++) begin
      case (kind)
        0:       img[i] = 16'd0;
        1:       img[i] = ((i % w) >= 2) ? 16'd100 : 16'd0;
        default: img[i] = 16'($urandom_range(0, 255));
      endcase
    end
  endtask

  function automatic logic [143:0] exp_window(input int idx);
    logic [143:0] w;
    int r;
    int c;
    r = idx / fw;
    c = idx % fw;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(i*3+j)*16 +: 16] = img[(r-2+i)*fw + (c-2+j)];
    return w;
  endfunction

  // Sobel magnitude |gx|+|gy| thresholded at 128, as the canny core reports it
  function automatic logic [7:0] core_model(input logic [143:0] w);
    int p[9];
    int gx;
    int gy;
    for (int k = 0; k < 9; k++) p[k] = int'(w[k*16 +: 16]);
    gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
    gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return ((gx + gy) > 128) ? 8'd255 : 8'd0;
  endfunction

  task automatic applyStimulus(input int w, input int h);
    @(negedge clk);
    bus.cfg_width  = DIM_W'(w);
    bus.cfg_height = DIM_W'(h);
    bus.go         = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic run_frame(input int stall_idx, input int stall_len, input bit abort_in_wait,
                           input int exp_results);
    int           n;
    int           pix_i;
    int           res_cnt;
    int           done_cnt;
    int           cycles;
    int           stall_left;
    int           idx;
    bit           core_pend;
    bit           abort_armed;
    bit           first;
    logic [7:0]   pend_dxy;
    logic [143:0] ew;
    n = fw * fh;
    pix_i = 0;
    res_cnt = 0;
    done_cnt = 0;
    cycles = 0;
    stall_left = stall_len;
    core_pend = 1'b0;
    abort_armed = 1'b0;
    first = 1'b1;
    pend_dxy = '0;
    result_log.delete();
    forever begin
      if (abort_armed) begin
        checkOutput("abort_busy", bus.busy, 1);
        reset = 1'b1;
        bus.core_valid = 1'b0;
        bus.pix_valid  = 1'b0;
        bus.edge_ready = 1'b0;
        break;
      end
      if (bus.done) begin
        done_cnt++;
        bus.pix_valid  = 1'b0;
        bus.core_valid = 1'b0;
        bus.edge_ready = 1'b0;
        break;
      end
      bus.core_valid = 1'b0;
      if (core_pend) begin
        bus.core_valid = 1'b1;
        bus.core_dxy   = {8'd0, pend_dxy};
        core_pend      = 1'b0;
      end
      if (bus.win_start) begin
        if (win_q.size() == 0) begin
          checkOutput("unexpected_win_start", 1, 0);
        end else begin
          idx = win_q.pop_front();
          ew  = exp_window(idx);
          checkOutput("win_bus", bus.win_bus, ew);
          if (first) first_win_obs = bus.win_bus;
          first     = 1'b0;
          pend_dxy  = core_model(ew);
          core_pend = 1'b1;
          if (abort_in_wait) abort_armed = 1'b1;
        end
      end
      if (bus.edge_valid) begin
        if (edge_q.size() == 0) begin
          checkOutput("unexpected_edge", 1, 0);
          bus.edge_ready = 1'b1;
        end else begin
          checkOutput("edge_data", bus.edge_data, edge_q[0][7:0]);
          checkOutput("edge_last", bus.edge_last, edge_q[0][8]);
          if (res_cnt == stall_idx && stall_left > 0) begin
            bus.edge_ready = 1'b0;
            checkOutput("stall_pix_ready", bus.pix_ready, 0);
            checkOutput("stall_win_start", bus.win_start, 0);
            stall_left--;
          end else begin
            bus.edge_ready = 1'b1;
            result_log.push_back(bus.edge_data);
            void'(edge_q.pop_front());
            res_cnt++;
          end
        end
      end else begin
        bus.edge_ready = 1'b0;
      end
      if (bus.pix_ready && pix_i < n) begin
        bus.pix_valid = 1'b1;
        bus.pix_data  = img[pix_i];
        if ((pix_i / fw) >= 2 && (pix_i % fw) >= 2) begin
          win_q.push_back(pix_i);
          edge_q.push_back({(pix_i == n-1), core_model(exp_window(pix_i))});
        end
        pix_i++;
      end else begin
        bus.pix_valid = 1'b0;
      end
      cycles++;
      if (cycles > 5000) begin
        checkOutput("frame_timeout", 1, 0);
        break;
      end
      @(negedge clk);
    end
    checkOutput("result_count", res_cnt, exp_results);
    if (!abort_in_wait) begin
      checkOutput("done_count", done_cnt, 1);
      checkOutput("edge_queue_empty", edge_q.size(), 0);
      @(negedge clk);
      checkOutput("done_one_cycle", bus.done, 0);
      checkOutput("busy_after_done", bus.busy, 0);
      checkOutput("pix_ready_after_done", bus.pix_ready, 0);
    end
  endtask

  initial begin
    logic [143:0] step_win;
    step_win = '0;
    step_win[32  +: 16] = 16'd100;
    step_win[80  +: 16] = 16'd100;
    step_win[128 +: 16] = 16'd100;

    reset          = 1'b1;
    bus.cfg_width  = '0;
    bus.cfg_height = '0;
    bus.go         = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.pix_data   = '0;
    bus.core_valid = 1'b0;
    bus.core_dxy   = '0;
    bus.edge_ready = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_cfg_err", bus.cfg_err, 0);
    checkOutput("rst_pix_ready", bus.pix_ready, 0);
    checkOutput("rst_win_start", bus.win_start, 0);
    checkOutput("rst_edge_valid", bus.edge_valid, 0);
    checkOutput("rst_edge_last", bus.edge_last, 0);
    checkOutput("rst_win_bus", bus.win_bus, 0);
    checkOutput("rst_edge_data", bus.edge_data, 0);
`ifdef CANNY_SEQ_EDGE_COUNT_EN
    checkOutput("rst_edge_count", bus.edge_count, 0);
`endif
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] 4x4 all-zero frame");
    fill_image(4, 4, 0);
    applyStimulus(4, 4);
    checkOutput("busy_after_go", bus.busy, 1);
    run_frame(-1, 0, 1'b0, 4);

    $display("[TB] 5x3 step frame");
    fill_image(5, 3, 1);
    applyStimulus(5, 3);
    run_frame(-1, 0, 1'b0, 3);
    checkOutput("step_first_window", first_win_obs, step_win);
    if (result_log.size() == 3) begin
      checkOutput("step_result0", result_log[0], 255);
      checkOutput("step_result1", result_log[1], 255);
      checkOutput("step_result2", result_log[2], 0);
    end else begin
      checkOutput("step_log_size", result_log.size(), 3);
    end
`ifdef CANNY_SEQ_EDGE_COUNT_EN
    checkOutput("edge_count_frame", bus.edge_count, 2);
`endif

    $display("[TB] 5x5 random frame with 10-cycle sink stall");
    fill_image(5, 5, 2);
    applyStimulus(5, 5);
`ifdef CANNY_SEQ_EDGE_COUNT_EN
    checkOutput("edge_count_cleared", bus.edge_count, 0);
`endif
    run_frame(1, 10, 1'b0, 9);

    $display("[TB] 3x3 minimum frame");
    fill_image(3, 3, 2);
    applyStimulus(3, 3);
    run_frame(-1, 0, 1'b0, 1);

    $display("[TB] rejected configurations");
    applyStimulus(2, 4);
    checkOutput("cfg_err_w2", bus.cfg_err, 1);
    checkOutput("busy_w2", bus.busy, 0);
    checkOutput("pix_ready_w2", bus.pix_ready, 0);
    @(negedge clk);
    checkOutput("cfg_err_pulse_w2", bus.cfg_err, 0);
    applyStimulus(MAX_WIDTH + 1, 2);
    checkOutput("cfg_err_wmax", bus.cfg_err, 1);
    checkOutput("busy_wmax", bus.busy, 0);
    checkOutput("pix_ready_wmax", bus.pix_ready, 0);
    @(negedge clk);
    checkOutput("cfg_err_pulse_wmax", bus.cfg_err, 0);

    $display("[TB] 8x8 frame aborted by reset in WAIT");
    fill_image(8, 8, 2);
    applyStimulus(8, 8);
    run_frame(-1, 0, 1'b1, 0);
    @(negedge clk);
    checkOutput("abort_busy_low", bus.busy, 0);
    checkOutput("abort_edge_valid", bus.edge_valid, 0);
    checkOutput("abort_edge_last", bus.edge_last, 0);
    checkOutput("abort_done", bus.done, 0);
    checkOutput("abort_pix_ready", bus.pix_ready, 0);
    reset = 1'b0;
    win_q.delete();
    edge_q.delete();
    @(negedge clk);

    $display("[TB] 4x4 random frame after abort");
    fill_image(4, 4, 2);
    applyStimulus(4, 4);
    run_frame(-1, 0, 1'b0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/canny_window_sequencer.md
Name: canny_window_sequencer

Overview:
Frame-level controller that feeds the Sobel/threshold core (canny). Accepts a raster pixel stream, builds 3x3 windows with two line buffers, issues one window per core start pulse and collects the core's dxy result. Results go out on a valid/ready edge stream with end-of-frame marking. Sits between the pixel source/SPI front end and the edge-map sink.

Parameters:
MAX_WIDTH, 640, line-buffer depth; largest legal cfg_width
DIM_W, 12, width of cfg_width/cfg_height and internal row/col counters

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  asynchronous, active-high; returns block to IDLE
cfg_width  in  DIM_W  frame width in pixels, sampled on go
cfg_height  in  DIM_W  frame height in pixels, sampled on go
go  in  1  one-cycle frame start request; honoured only in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after last edge result handed off
cfg_err  out  1  one-cycle pulse when go is rejected for illegal cfg
pix_valid  in  1  source pixel valid
pix_ready  out  1  sequencer accepts pixel this cycle
pix_data  in  16  pixel value
win_start  out  1  one-cycle start strobe to the core
win_bus  out  144  window, row-major: p11 at [15:0], p12 [31:16] ... p33 [143:128]
core_valid  in  1  core result valid (core data_occur)
core_dxy  in  16  core thresholded output (0 or 255)
edge_valid  out  1  edge result valid
edge_ready  in  1  sink accepts edge result
edge_data  out  8  core_dxy[7:0] of the window
edge_last  out  1  high with final result of the frame

Behaviour:
- Reset values: busy, done, cfg_err, pix_ready, win_start, edge_valid, edge_last = 0; win_bus, edge_data = 0; state = IDLE; counters 0. Line-buffer contents not reset.
- States: IDLE, ACCEPT, ISSUE, WAIT, OUT, DONE.
- IDLE: on go, if 3 <= cfg_width <= MAX_WIDTH and cfg_height >= 3, latch cfg, clear row/col, go ACCEPT; else pulse cfg_err next cycle, stay IDLE. go outside IDLE ignored.
- ACCEPT: pix_ready = 1 (combinational from state). On pix_valid at (row r, col c): lb1[c] <= lb0[c]; lb0[c] <= pix_data; shift window columns left, new right column = {lb1[c], lb0[c], pix_data} (top to bottom). Advance col; at col = width-1 wrap to 0, row++. If r>=2 and c>=2 go ISSUE, else stay ACCEPT.
- ISSUE: win_start = 1 for exactly one cycle, win_bus holds the window (p11 = pixel (r-2,c-2), p33 = (r,c)); win_bus stays stable until the next accepted pixel. Go WAIT.
- WAIT: wait for core_valid; on core_valid latch edge_data = core_dxy[7:0], edge_last = (r == height-1 && c == width-1); go OUT. core_valid in any other state is ignored.
- OUT: edge_valid = 1, edge_data/edge_last stable until edge_ready. On handshake: if edge_last go DONE, else ACCEPT.
- DONE: done = 1 one cycle, go IDLE.
- Exactly (width-2)*(height-2) edge results per frame, raster order. At most one window in flight; pix_ready low in ISSUE/WAIT/OUT.
- Minimum latency: pixel accept -> win_start 1 cycle; win_start -> core_valid per core (1 cycle for canny); core_valid -> edge_valid 1 cycle.
- Reset asserted mid-frame: immediate return to IDLE, outputs to reset values; partial frame discarded, no done pulse.

Optional Feature:
CANNY_SEQ_EDGE_COUNT_EN: when defined, adds output edge_count [2*DIM_W-1:0], cleared on accepted go, incremented on each edge handshake with edge_data = 255, held after DONE until next go; reset value 0. When undefined the port and counter do not exist; all other behaviour identical.

Test Plan:
- 4x4 frame, all pixels 0 -> 4 edge results all 0, edge_last only on 4th, done pulse once, busy low after.
- 5x3 frame, every row 0,0,100,100,100 -> edge_data 255, 255, 0; win_bus of first window p13=p23=p33=100, others 0.
- Edge_ready held low 10 cycles while edge_valid high -> edge_valid/edge_data/edge_last stable, pix_ready 0, no win_start; release -> frame completes normally.
- go with cfg_width=2 (and separately cfg_width=MAX_WIDTH+1, cfg_height=2) -> cfg_err pulse, busy stays 0, pix_ready 0.
- reset asserted during WAIT of 8x8 frame, then new 4x4 frame -> no edge output from aborted frame, new frame yields exactly 4 results.
- CANNY_SEQ_EDGE_COUNT_EN defined, 5x3 step frame -> edge_count = 2 after done; next go clears to 0.
